// File: rtl/mvm_uart_pkg.sv
// Shared types and UART frame constants for the MVM UART host.
package mvm_uart_pkg;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, OUT} state_t;

  localparam int unsigned START_BITS = 1;
  localparam int unsigned STOP_BITS  = 4;

  // Counter width for a limit, never narrower than one bit.
  function automatic int unsigned cw(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/mvm_uart_host_rx.sv
// UART byte receiver: 2-flop synchronizer, start detection with glitch reject,
// mid-bit sampling and stop-bit check; emits a 1-cycle byte_valid with the byte.
module uart_byte_rx
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 200_000_000/9600,
  parameter int BITS_PER_WORD    = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     en,
  input  logic                     rx,
  output logic                     byte_valid,
  output logic [BITS_PER_WORD-1:0] byte_data
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam int unsigned CW   = cw(CLOCKS_PER_PULSE);
  localparam int unsigned BW   = cw(BITS_PER_WORD);
  localparam int unsigned HALF = CLOCKS_PER_PULSE / 2;

  rx_state_t               state, state_nxt;
  logic [1:0]              sync;
  logic                    prev;
  logic                    line;
  logic [CW-1:0]           clk_cnt;
  logic [BW-1:0]           bit_cnt;
  logic [BITS_PER_WORD-1:0] shreg;
  logic                    tick_half, tick_full;

  assign line      = sync[1];
  assign tick_half = (clk_cnt == CW'(HALF - 1));
  assign tick_full = (clk_cnt == CW'(CLOCKS_PER_PULSE - 1));
  assign byte_data = shreg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync <= 2'b11;
      prev <= 1'b1;
    end else begin
      sync <= {sync[0], rx};
      prev <= line;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= RX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_valid = 1'b0;
    case (state)
      RX_IDLE:  if (prev && !line) state_nxt = RX_START;
      // Line back high at half a bit means the falling edge was a glitch.
      RX_START: if (tick_half) state_nxt = line ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_cnt == BW'(BITS_PER_WORD - 1)) state_nxt = RX_STOP;
      RX_STOP:  if (tick_full) begin
        state_nxt  = RX_IDLE;
        byte_valid = line;
      end
      default:  state_nxt = RX_IDLE;
    endcase
    if (!en) begin
      state_nxt  = RX_IDLE;
      byte_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      clk_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      if (state_nxt != state || tick_full) clk_cnt <= '0;
      else                                 clk_cnt <= clk_cnt + 1'b1;
      if (state != RX_DATA) begin
        bit_cnt <= '0;
      end else if (tick_full) begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg   <= {line, shreg[BITS_PER_WORD-1:1]};
      end
    end
  end

endmodule

// File: rtl/mvm_uart_host.sv
// Host bridge: sends a packed K/X request over UART, collects the Y result bytes.
// Optional response timeout with sticky err is enabled by defining MVM_HOST_TIMEOUT_EN.
module mvm_uart_host
  import mvm_uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 200_000_000/9600,
  parameter int BITS_PER_WORD    = 8,
  parameter int R                = 8,
  parameter int C                = 8,
  parameter int W_X              = 8,
  parameter int W_K              = 8,
  parameter int W_Y_OUT          = 32,
  parameter int TIMEOUT_CYCLES   = 2**24,
  localparam int W_BUS_KX        = R*C*W_K + C*W_X,
  localparam int W_BUS_Y         = R*W_Y_OUT
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_axis_kx_tvalid,
  output logic                s_axis_kx_tready,
  input  logic [W_BUS_KX-1:0] s_axis_kx_tdata,
  output logic                m_axis_y_tvalid,
  input  logic                m_axis_y_tready,
  output logic [W_BUS_Y-1:0]  m_axis_y_tdata,
  output logic                tx,
  input  logic                rx,
  output logic                err
);

  localparam int unsigned NUM_TX     = W_BUS_KX / BITS_PER_WORD;
  localparam int unsigned NUM_RX     = W_BUS_Y / BITS_PER_WORD;
  localparam int unsigned FRAME_BITS = START_BITS + BITS_PER_WORD + STOP_BITS;
  localparam int unsigned CW         = cw(CLOCKS_PER_PULSE);
  localparam int unsigned FW         = cw(FRAME_BITS);
  localparam int unsigned TW         = cw(NUM_TX);
  localparam int unsigned YW         = cw(NUM_RX);

  if (W_BUS_KX % BITS_PER_WORD != 0) begin : g_kx_width_chk
    $error("W_BUS_KX must be a multiple of BITS_PER_WORD");
  end
  if (W_BUS_Y % BITS_PER_WORD != 0) begin : g_y_width_chk
    $error("W_BUS_Y must be a multiple of BITS_PER_WORD");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t                   state, state_nxt;
  logic [W_BUS_KX-1:0]      kx_sr;
  logic [CW-1:0]            clk_cnt;
  logic [FW-1:0]            bit_cnt;
  logic [TW-1:0]            tx_cnt;
  logic [YW-1:0]            rx_cnt;
  logic                     rx_full;
  logic                     rx_en;
  logic                     byte_valid;
  logic [BITS_PER_WORD-1:0] byte_data;
  logic                     kx_hs, y_hs;
  logic                     bit_end, frame_end, tx_done, last_byte, timeout;

  assign kx_hs     = s_axis_kx_tvalid && s_axis_kx_tready;
  assign y_hs      = m_axis_y_tvalid && m_axis_y_tready;
  assign bit_end   = (clk_cnt == CW'(CLOCKS_PER_PULSE - 1));
  assign frame_end = bit_end && (bit_cnt == FW'(FRAME_BITS - 1));
  assign tx_done   = frame_end && (tx_cnt == TW'(NUM_TX - 1));
  assign last_byte = byte_valid && (rx_cnt == YW'(NUM_RX - 1));
  // A fast accelerator may finish replying before the request is fully sent.
  assign rx_en     = (state == SEND || state == WAIT_RX) && !rx_full;

  uart_byte_rx #(
    .CLOCKS_PER_PULSE(CLOCKS_PER_PULSE),
    .BITS_PER_WORD   (BITS_PER_WORD)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .en        (rx_en),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

`ifdef MVM_HOST_TIMEOUT_EN
  localparam int unsigned OW = cw(TIMEOUT_CYCLES);
  logic [OW-1:0] to_cnt;

  assign timeout = (state == WAIT_RX) && (to_cnt == OW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state != WAIT_RX || byte_valid) to_cnt <= '0;
      else                                to_cnt <= to_cnt + 1'b1;
      if (timeout && !last_byte) err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (kx_hs) state_nxt = SEND;
      SEND:    if (tx_done) state_nxt = (rx_full || last_byte) ? OUT : WAIT_RX;
      WAIT_RX: begin
        if (last_byte)    state_nxt = OUT;
        else if (timeout) state_nxt = IDLE;
      end
      OUT:     if (y_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_axis_kx_tready <= 1'b0;
      m_axis_y_tvalid  <= 1'b0;
      m_axis_y_tdata   <= '0;
      tx               <= 1'b1;
      kx_sr            <= '0;
      clk_cnt          <= '0;
      bit_cnt          <= '0;
      tx_cnt           <= '0;
      rx_cnt           <= '0;
      rx_full          <= 1'b0;
    end else begin
      s_axis_kx_tready <= (state_nxt == IDLE);
      m_axis_y_tvalid  <= (state_nxt == OUT);

      case (state)
        IDLE: if (kx_hs) begin
          kx_sr   <= s_axis_kx_tdata;
          tx      <= 1'b0;
          clk_cnt <= '0;
          bit_cnt <= '0;
          tx_cnt  <= '0;
          rx_cnt  <= '0;
          rx_full <= 1'b0;
        end
        SEND: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (frame_end) begin
              bit_cnt <= '0;
              tx_cnt  <= tx_cnt + 1'b1;
              tx      <= tx_done;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // Consuming one data bit per shift leaves the next byte at the bottom.
              if (bit_cnt < FW'(BITS_PER_WORD)) begin
                tx    <= kx_sr[0];
                kx_sr <= kx_sr >> 1;
              end else begin
                tx    <= 1'b1;
              end
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: ;
      endcase

      if (byte_valid) begin
        m_axis_y_tdata <= {byte_data, m_axis_y_tdata[W_BUS_Y-1:BITS_PER_WORD]};
        if (last_byte) begin
          rx_cnt  <= '0;
          rx_full <= 1'b1;
        end else begin
          rx_cnt  <= rx_cnt + 1'b1;
        end
      end else if (timeout) begin
        m_axis_y_tdata <= '0;
        rx_cnt         <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mvm_uart_host.sv
// Directed bench for mvm_uart_host: reset, TX framing, RX assembly, glitch/framing
// rejection, backpressure, timeout (when MVM_HOST_TIMEOUT_EN is defined) and mid-op reset.
module tb_mvm_uart_host;

  localparam int CPP = 4;
  localparam int WKX = 48;
  localparam int WY  = 64;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           kx_vld = 1'b0;
  logic           kx_rdy;
  logic [WKX-1:0] kx_dat = '0;
  logic           y_vld;
  logic           y_rdy = 1'b0;
  logic [WY-1:0]  y_dat;
  logic           tx;
  logic           rx = 1'b1;
  logic           err;

  int n_tests = 0;
  int n_fail  = 0;

  logic txs [312];

  always #5 clk = ~clk;

  mvm_uart_host #(
    .CLOCKS_PER_PULSE(CPP),
    .BITS_PER_WORD   (8),
    .R               (2),
    .C               (2),
    .W_X             (8),
    .W_K             (8),
    .W_Y_OUT         (32),
    .TIMEOUT_CYCLES  (1000)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .s_axis_kx_tvalid(kx_vld),
    .s_axis_kx_tready(kx_rdy),
    .s_axis_kx_tdata (kx_dat),
    .m_axis_y_tvalid (y_vld),
    .m_axis_y_tready (y_rdy),
    .m_axis_y_tdata  (y_dat),
    .tx              (tx),
    .rx              (rx),
    .err             (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic uart_send(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    step(CPP);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      step(CPP);
    end
    rx = stop_bit;
    step(CPP);
    rx = 1'b1;
    step(2 * CPP);
  endtask

  task automatic wait_y(input string tag);
    int k = 0;
    while (!y_vld && k < 200) begin
      step(1);
      k++;
    end
    check(tag, y_vld, 1'b1);
  endtask

  initial begin
    int bad;
    logic [12:0] obs;
    logic [12:0] exp_frame;
    logic [7:0]  b8;
    logic [7:0]  good [8];

    // Reset state
    step(5);
    check("rst_tx", tx, 1'b1);
    check("rst_tready", kx_rdy, 1'b0);
    check("rst_yvalid", y_vld, 1'b0);
    check("rst_err", err, 1'b0);
    rstn = 1'b1;
    step(1);
    check("rel_tready", kx_rdy, 1'b1);

    // TX framing
    kx_vld = 1'b1;
    kx_dat = 48'h060504030201;
    step(1);
    kx_vld = 1'b0;
    bad = 0;
    for (int i = 0; i < 312; i++) begin
      txs[i] = tx;
      if (kx_rdy !== 1'b0) bad++;
      step(1);
    end
    check("tx_start_first", txs[0], 1'b0);
    check("tx_tready_low", bad, 0);
    check("tx_idle_after", tx, 1'b1);
    bad = 0;
    for (int b = 0; b < 6; b++) begin
      obs = '0;
      for (int k = 0; k < 13; k++) begin
        obs[k] = txs[b*52 + k*4];
        for (int j = 1; j < 4; j++)
          if (txs[b*52 + k*4 + j] !== obs[k]) bad++;
      end
      b8 = 8'(b + 1);
      exp_frame = {4'hF, b8, 1'b0};
      check($sformatf("tx_frame%0d", b), obs, exp_frame);
    end
    check("tx_bit_hold", bad, 0);

    // RX assembly and output hold
    uart_send(8'hFF, 1'b1);
    uart_send(8'hFF, 1'b1);
    uart_send(8'hFF, 1'b1);
    uart_send(8'hFF, 1'b1);
    uart_send(8'h05, 1'b1);
    uart_send(8'h00, 1'b1);
    uart_send(8'h00, 1'b1);
    check("rx_early_valid", y_vld, 1'b0);
    uart_send(8'h00, 1'b1);
    wait_y("rx_valid");
    check("rx_data", y_dat, 64'h00000005_FFFFFFFF);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (y_vld !== 1'b1 || y_dat !== 64'h00000005_FFFFFFFF || kx_rdy !== 1'b0) bad++;
      step(1);
    end
    check("rx_hold", bad, 0);
    y_rdy = 1'b1;
    step(1);
    y_rdy = 1'b0;
    check("rx_valid_drop", y_vld, 1'b0);
    check("rx_idle_tready", kx_rdy, 1'b1);

    // Byte in IDLE is dropped; then glitch and framing error are rejected
    uart_send(8'hAB, 1'b1);
    kx_vld = 1'b1;
    kx_dat = '0;
    step(1);
    kx_vld = 1'b0;
    step(312);
    rx = 1'b0;
    step(1);
    rx = 1'b1;
    step(3 * CPP);
    uart_send(8'h5A, 1'b0);
    good = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 7; i++) uart_send(good[i], 1'b1);
    check("glitch_early_valid", y_vld, 1'b0);
    uart_send(good[7], 1'b1);
    wait_y("glitch_valid");
    check("glitch_data", y_dat, 64'h8877665544332211);

    // Backpressure: new request waits for the y handshake
    kx_vld = 1'b1;
    kx_dat = '0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (kx_rdy !== 1'b0) bad++;
      step(1);
    end
    check("bp_tready_low", bad, 0);
    check("bp_yvalid_held", y_vld, 1'b1);
    y_rdy = 1'b1;
    step(1);
    y_rdy = 1'b0;
    check("bp_tready_after", kx_rdy, 1'b1);
    step(1);
    kx_vld = 1'b0;
    check("bp_accepted", kx_rdy, 1'b0);
    check("bp_start_bit", tx, 1'b0);
    step(312);

`ifdef MVM_HOST_TIMEOUT_EN
    step(999);
    check("to_err_before", err, 1'b0);
    step(1);
    check("to_err_set", err, 1'b1);
    step(1);
    check("to_tready", kx_rdy, 1'b1);
    check("to_err_sticky", err, 1'b1);
`else
    step(1200);
    check("noto_err", err, 1'b0);
    check("noto_waiting", kx_rdy, 1'b0);
`endif

    // Reset in the middle of a transfer
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
    step(1);
    check("mid_rel_tready", kx_rdy, 1'b1);
    kx_vld = 1'b1;
    kx_dat = '0;
    step(1);
    kx_vld = 1'b0;
    step(9);
    check("mid_tx_data_bit", tx, 1'b0);
    rstn = 1'b0;
    step(1);
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_tready", kx_rdy, 1'b0);
    check("mid_rst_yvalid", y_vld, 1'b0);
    check("mid_rst_err", err, 1'b0);
    rstn = 1'b1;
    step(1);
    check("mid_rel_tready2", kx_rdy, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mvm_uart_host.md
MVM_UART_HOST -- requirements
Module: mvm_uart_host

Interface
REQ-001 SHALL have parameter CLOCKS_PER_PULSE, default 200_000_000/9600, clocks per UART bit.
REQ-002 SHALL have parameter BITS_PER_WORD, default 8, data bits per UART frame.
REQ-003 SHALL have parameters R=8, C=8, W_X=8, W_K=8, W_Y_OUT=32, which fix the matrix/vector geometry: W_BUS_KX=R*C*W_K+C*W_X and W_BUS_Y=R*W_Y_OUT.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2**24, response timeout; used only with MVM_HOST_TIMEOUT_EN.
REQ-005 SHALL have port clk, input, 1 bit: the single clock. Reset is synchronous and active-low.
REQ-006 SHALL have port rstn, input, 1 bit: synchronous active-low reset.
REQ-007 SHALL have port s_axis_kx_tvalid / s_axis_kx_tready / s_axis_kx_tdata, in/out/in, 1/1/W_BUS_KX bits: request stream carrying packed K and X.
REQ-008 SHALL have port m_axis_y_tvalid / m_axis_y_tready / m_axis_y_tdata, out/in/out, 1/1/W_BUS_Y bits: result stream.
REQ-009 SHALL have port tx, output, 1 bit: UART line to the accelerator.
REQ-010 SHALL have port rx, input, 1 bit: UART line from the accelerator.
REQ-011 SHALL have port err, output, 1 bit: sticky timeout flag.

Function
REQ-012 SHALL use FSM states IDLE, SEND, WAIT_RX, OUT; IDLE->SEND on kx handshake; SEND->WAIT_RX after the last TX byte's final stop bit; WAIT_RX->OUT after byte W_BUS_Y/8 is received; OUT->IDLE on y handshake.
REQ-013 SHALL drive s_axis_kx_tready=1 only in IDLE and capture tdata into a shift register on the handshake.
REQ-014 SHALL transmit W_BUS_KX/8 bytes LSB-byte first, each frame being 1 start bit (0), BITS_PER_WORD data bits LSB first, and 4 stop bits (1), for 13 bit periods total.
REQ-015 SHALL hold each bit for exactly CLOCKS_PER_PULSE cycles, drive the start bit of byte 0 in the cycle after the kx handshake, and send bytes back-to-back.
REQ-016 SHALL pass rx through a 2-flop synchronizer whose flops reset to 1.
REQ-017 SHALL detect a start bit on a falling edge, then re-sample at CLOCKS_PER_PULSE/2; if the line is high at that point, the start is a glitch and SHALL be ignored.
REQ-018 SHALL sample data bits at mid-bit and assemble received bytes LSB-byte first into m_axis_y_tdata.
REQ-019 SHALL discard a received byte whose stop-bit sample is 0 (framing error), not count it, and wait for the line to go high before accepting the next start.
REQ-020 SHALL enable the receiver in SEND and WAIT_RX only; bytes arriving in IDLE or OUT are dropped.
REQ-021 SHALL assert m_axis_y_tvalid in the cycle after the last byte's stop sample, and hold valid and data stable until tready=1.
REQ-022 SHALL NOT accept a new kx request while a result is pending; tready stays 0 through OUT.
REQ-023 SHALL keep counters sized with $clog2 of their limits.
REQ-024 SHALL statically error (elaboration-time assert) when W_BUS_KX or W_BUS_Y is not a multiple of BITS_PER_WORD.

Reset
REQ-025 SHALL, while rstn=0 at a clk edge, set state=IDLE, tx=1, s_axis_kx_tready=0, m_axis_y_tvalid=0, m_axis_y_tdata=0, err=0, and clear all counters.
REQ-026 SHALL raise s_axis_kx_tready the first cycle after rstn returns to 1.
REQ-027 SHALL abort any transfer when reset occurs mid-operation, with tx=1 from the next edge and no partial output.

Configuration
REQ-028 SHALL, with MVM_HOST_TIMEOUT_EN defined, count cycles in WAIT_RX (restarting on each accepted byte); when the count reaches TIMEOUT_CYCLES, set err=1 (sticky until reset), drop partial data, and return to IDLE.
REQ-029 SHALL, without MVM_HOST_TIMEOUT_EN, tie err to 0, wait indefinitely in WAIT_RX, and omit the timeout counter.

Structure
REQ-030 SHALL place the state enum and the frame constants (start/stop bit counts, stop bits = 4) in package mvm_uart_pkg.
REQ-031 SHALL contain one sub-module, uart_byte_rx, that performs synchronizing, start detection, mid-bit sampling and framing check, and emits a 1-cycle byte_valid with the byte.

Verification
REQ-032 SHALL verify reset: rstn=0 for 5 cycles -> tx=1, tready=0, m_valid=0, err=0; tready=1 in the first cycle after release.
REQ-033 SHALL verify TX framing with CLOCKS_PER_PULSE=4, R=C=2 (6 kx bytes, 8 y bytes): kx=48'h060504030201 -> bytes 01..06, 52 cycles each, start bit in the cycle after the handshake, and tready=0 for all 312 cycles.
REQ-034 SHALL verify RX assembly: a model sends FF,FF,FF,FF,05,00,00,00 -> m_axis_y_tdata=64'h00000005_FFFFFFFF, with valid and data held while tready is held 0 for 10 cycles.
REQ-035 SHALL verify a glitch and a framing error: a 1-cycle rx low pulse, then a byte with stop=0 -> neither counted, and the next 8 good bytes produce the correct y.
REQ-036 SHALL verify backpressure: kx_tvalid asserted while OUT is pending -> tready=0 until the y handshake, with the new request accepted the cycle after.
REQ-037 SHALL verify the timeout with MVM_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=1000: no response -> err=1 exactly 1000 cycles after WAIT_RX entry, and tready=1 in the cycle after; without the macro, the block stays in WAIT_RX and err=0.
